// File: rtl/status_reg_pkg.sv
// Shared definitions for the 6502-compatible status register: flag commands,
// P bit positions, branch flag selects and the ALU mode enum.
package status_reg_pkg;

    typedef enum logic [2:0] {
        FLAG_NONE = 3'd0,
        FLAG_CLC  = 3'd1,
        FLAG_SEC  = 3'd2,
        FLAG_CLI  = 3'd3,
        FLAG_SEI  = 3'd4,
        FLAG_CLV  = 3'd5,
        FLAG_CLD  = 3'd6,
        FLAG_SED  = 3'd7
    } flag_cmd_t;

    typedef enum logic [2:0] {
        ALU_ADC = 3'd0,
        ALU_SBC = 3'd1,
        ALU_AND = 3'd2,
        ALU_ORA = 3'd3,
        ALU_EOR = 3'd4,
        ALU_CMP = 3'd5,
        ALU_SHL = 3'd6,
        ALU_SHR = 3'd7
    } alu_mode_t;

    localparam int P_C = 0;
    localparam int P_Z = 1;
    localparam int P_I = 2;
    localparam int P_D = 3;
    localparam int P_B = 4;
    localparam int P_U = 5;
    localparam int P_V = 6;
    localparam int P_N = 7;

    localparam logic [1:0] BR_SEL_N = 2'b00;
    localparam logic [1:0] BR_SEL_V = 2'b01;
    localparam logic [1:0] BR_SEL_C = 2'b10;
    localparam logic [1:0] BR_SEL_Z = 2'b11;

    function automatic logic [2:0] branch_flag_idx(input logic [1:0] sel);
        logic [2:0] idx;
        case (sel)
            BR_SEL_N: idx = 3'(P_N);
            BR_SEL_V: idx = 3'(P_V);
            BR_SEL_C: idx = 3'(P_C);
            default:  idx = 3'(P_Z);
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/status_reg_if.sv
// Decoder/ALU-facing bundle of the status register. Every control input is a
// single-cycle qualifier sampled at the clock edge; there is no backpressure.
interface status_reg_if
    import status_reg_pkg::*;
();
    logic       alu_carry;
    logic       alu_overflow;
    logic       alu_zero;
    logic       alu_sign;
    logic       upd_nz;
    logic       upd_c;
    logic       upd_v;
    logic       bit_op;
    flag_cmd_t  flag_cmd;
    logic       pull;
    logic       rti;
    logic [7:0] data_in;
    logic       push_brk;
    logic       instr_done;
    logic [2:0] branch_sel;
    logic [7:0] p_out;
    logic [7:0] p_push;
    logic       carry_in;
    logic       branch_taken;
    logic       irq_mask;

    modport master (
        output alu_carry, alu_overflow, alu_zero, alu_sign,
        output upd_nz, upd_c, upd_v, bit_op, flag_cmd,
        output pull, rti, data_in, push_brk, instr_done, branch_sel,
        input  p_out, p_push, carry_in, branch_taken, irq_mask
    );

    modport slave (
        input  alu_carry, alu_overflow, alu_zero, alu_sign,
        input  upd_nz, upd_c, upd_v, bit_op, flag_cmd,
        input  pull, rti, data_in, push_brk, instr_done, branch_sel,
        output p_out, p_push, carry_in, branch_taken, irq_mask
    );
endinterface

// File: rtl/status_reg_branch_eval.sv
// Branch condition: selected P flag compared against the wanted value.
// Purely combinational so the decoder can reuse it for lookahead.
module status_reg_branch_eval
    import status_reg_pkg::*;
(
    input  logic [7:0] p,
    input  logic [2:0] branch_sel,
    output logic       branch_taken
);
    logic [2:0] flag_idx;

    always_comb begin
        flag_idx     = branch_flag_idx(branch_sel[2:1]);
        branch_taken = (p[flag_idx] == branch_sel[0]);
    end
endmodule

// File: rtl/status_reg.sv
// Processor status register (P) with delayed interrupt mask and branch eval.
// Define STATUS_DFLAG_EN to store the D flag; otherwise D always reads 0.
module status_reg
    import status_reg_pkg::*;
#(
    parameter logic [7:0] RESET_P = 8'h24
) (
    input  logic       clk,
    input  logic       reset_n,
    status_reg_if.slave bus
);

`ifdef STATUS_DFLAG_EN
    localparam logic D_EN = 1'b1;
`else
    localparam logic D_EN = 1'b0;
`endif

    // B and bit5 are not real storage: they are pinned on every write path.
    localparam logic [7:0] RESET_FIXED = {RESET_P[7:6], 1'b1, 1'b0,
                                          RESET_P[3] & D_EN, RESET_P[2:0]};

    logic [7:0] p_q, p_d;
    logic       irq_mask_q, irq_mask_d;

    always_comb begin
        p_d = p_q;
        if (bus.pull) begin
            p_d = {bus.data_in[7:6], 1'b1, 1'b0, bus.data_in[3:0]};
        end else begin
            if (bus.upd_c)  p_d[P_C] = bus.alu_carry;
            if (bus.upd_v)  p_d[P_V] = bus.alu_overflow;
            if (bus.upd_nz) begin
                p_d[P_N] = bus.alu_sign;
                p_d[P_Z] = bus.alu_zero;
            end
            if (bus.bit_op) begin
                p_d[P_N] = bus.data_in[7];
                p_d[P_V] = bus.data_in[6];
                p_d[P_Z] = bus.alu_zero;
            end
            case (bus.flag_cmd)
                FLAG_CLC: p_d[P_C] = 1'b0;
                FLAG_SEC: p_d[P_C] = 1'b1;
                FLAG_CLI: p_d[P_I] = 1'b0;
                FLAG_SEI: p_d[P_I] = 1'b1;
                FLAG_CLV: p_d[P_V] = 1'b0;
                FLAG_CLD: p_d[P_D] = 1'b0;
                FLAG_SED: p_d[P_D] = 1'b1;
                default:  ;
            endcase
        end
        p_d[P_D] = p_d[P_D] & D_EN;
        p_d[P_U] = 1'b1;
        p_d[P_B] = 1'b0;
    end

    // The poll sees the I flag from before the finishing instruction, except
    // RTI, whose restored I must be honoured immediately.
    always_comb begin
        irq_mask_d = irq_mask_q;
        if (bus.pull && bus.rti) begin
            irq_mask_d = bus.data_in[P_I];
        end else if (bus.instr_done) begin
            irq_mask_d = p_q[P_I];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            p_q        <= RESET_FIXED;
            irq_mask_q <= 1'b1;
        end else begin
            p_q        <= p_d;
            irq_mask_q <= irq_mask_d;
        end
    end

    assign bus.p_out    = p_q;
    assign bus.p_push   = {p_q[P_N], p_q[P_V], 1'b1, bus.push_brk,
                           p_q[P_D], p_q[P_I], p_q[P_Z], p_q[P_C]};
    assign bus.carry_in = p_q[P_C];
    assign bus.irq_mask = irq_mask_q;

    status_reg_branch_eval u_branch_eval (
        .p            (p_q),
        .branch_sel   (bus.branch_sel),
        .branch_taken (bus.branch_taken)
    );

endmodule

// File: tb/tb_status_reg.sv
// Self-checking bench for status_reg: directed scenarios plus a randomized run
// against a flag-level reference model.
module tb_status_reg;
    import status_reg_pkg::*;

`ifdef STATUS_DFLAG_EN
    localparam bit DEN = 1'b1;
`else
    localparam bit DEN = 1'b0;
`endif

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    status_reg_if bus();

    status_reg #(.RESET_P(8'h24)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the architectural flags as individual bits.
    bit m_n, m_v, m_d, m_i, m_z, m_c, m_irq;

    function automatic logic [7:0] m_p();
        return {m_n, m_v, 1'b1, 1'b0, m_d, m_i, m_z, m_c};
    endfunction

    function automatic logic [7:0] m_push(input bit brk);
        return {m_n, m_v, 1'b1, brk, m_d, m_i, m_z, m_c};
    endfunction

    function automatic bit m_branch(input logic [2:0] sel);
        bit f;
        case (sel[2:1])
            2'd0: f = m_n;
            2'd1: f = m_v;
            2'd2: f = m_c;
            default: f = m_z;
        endcase
        return f == sel[0];
    endfunction

    task automatic model_step();
        bit old_i;
        old_i = m_i;
        if (!reset_n) begin
            {m_n, m_v, m_i, m_z, m_c} = 5'b00100;
            m_d   = 1'b0;
            m_irq = 1'b1;
        end else begin
            if (bus.pull) begin
                m_n = bus.data_in[7]; m_v = bus.data_in[6];
                m_d = DEN & bus.data_in[3]; m_i = bus.data_in[2];
                m_z = bus.data_in[1]; m_c = bus.data_in[0];
            end else begin
                // apply lowest priority first so higher sources overwrite
                if (bus.upd_c)  m_c = bus.alu_carry;
                if (bus.upd_v)  m_v = bus.alu_overflow;
                if (bus.upd_nz) begin m_n = bus.alu_sign; m_z = bus.alu_zero; end
                if (bus.bit_op) begin
                    m_n = bus.data_in[7]; m_v = bus.data_in[6]; m_z = bus.alu_zero;
                end
                case (bus.flag_cmd)
                    FLAG_CLC: m_c = 0;
                    FLAG_SEC: m_c = 1;
                    FLAG_CLI: m_i = 0;
                    FLAG_SEI: m_i = 1;
                    FLAG_CLV: m_v = 0;
                    FLAG_CLD: m_d = 0;
                    FLAG_SED: m_d = DEN;
                    default: ;
                endcase
            end
            if (bus.pull && bus.rti) m_irq = bus.data_in[2];
            else if (bus.instr_done) m_irq = old_i;
        end
    endtask

    task automatic idle_inputs();
        bus.alu_carry = 0; bus.alu_overflow = 0; bus.alu_zero = 0; bus.alu_sign = 0;
        bus.upd_nz = 0; bus.upd_c = 0; bus.upd_v = 0; bus.bit_op = 0;
        bus.flag_cmd = FLAG_NONE; bus.pull = 0; bus.rti = 0; bus.data_in = 8'h00;
        bus.push_brk = 0; bus.instr_done = 0; bus.branch_sel = 3'b000;
    endtask

    // Advance one edge with the current inputs, then release the strobes.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        bus.branch_sel = 3'b100;
        #1;
        checks++;
        if (bus.p_out !== 8'h24) begin errors++; $display("FAIL reset_p_out: got %h expected 24", bus.p_out); end
        checks++;
        if (bus.carry_in !== 1'b0) begin errors++; $display("FAIL reset_carry_in: got %b expected 0", bus.carry_in); end
        checks++;
        if (bus.irq_mask !== 1'b1) begin errors++; $display("FAIL reset_irq_mask: got %b expected 1", bus.irq_mask); end
        checks++;
        if (bus.branch_taken !== 1'b1) begin errors++; $display("FAIL reset_bcc_taken: got %b expected 1", bus.branch_taken); end
        checks++;
        if (bus.p_push !== 8'h24) begin errors++; $display("FAIL reset_p_push: got %h expected 24", bus.p_push); end
        bus.branch_sel = 3'b000;
    endtask

    task automatic test_alu_update();
        bus.upd_nz = 1; bus.upd_c = 1; bus.upd_v = 1;
        bus.alu_sign = 1; bus.alu_zero = 0; bus.alu_carry = 1; bus.alu_overflow = 1;
        tick();
        checks++;
        if (bus.p_out !== 8'hE5) begin errors++; $display("FAIL alu_p_out: got %h expected e5", bus.p_out); end
        checks++;
        if (bus.carry_in !== 1'b1) begin errors++; $display("FAIL alu_carry_in: got %b expected 1", bus.carry_in); end
        bus.flag_cmd = FLAG_CLC; bus.upd_c = 1; bus.alu_carry = 1;
        tick();
        checks++;
        if (bus.carry_in !== 1'b0) begin errors++; $display("FAIL clc_over_upd_c: got %b expected 0", bus.carry_in); end
        checks++;
        if (bus.p_out !== 8'hE4) begin errors++; $display("FAIL clc_p_out: got %h expected e4", bus.p_out); end
    endtask

    task automatic test_bit_op();
        bus.bit_op = 1; bus.data_in = 8'hC0; bus.alu_zero = 1; bus.upd_nz = 1; bus.alu_sign = 0;
        tick();
        checks++;
        if (bus.p_out[7:6] !== 2'b11 || bus.p_out[1] !== 1'b1) begin
            errors++; $display("FAIL bit_op_nvz: got %h expected N=V=Z=1", bus.p_out);
        end
        // BIT with bit7/bit6 clear must clear N and V even with upd_nz asserting sign
        bus.bit_op = 1; bus.data_in = 8'h00; bus.alu_zero = 0; bus.upd_nz = 1; bus.alu_sign = 1;
        tick();
        checks++;
        if (bus.p_out !== 8'h24) begin errors++; $display("FAIL bit_op_clear: got %h expected 24", bus.p_out); end
    endtask

    task automatic test_irq_mask_delay();
        bus.flag_cmd = FLAG_CLI; bus.instr_done = 1;
        tick();
        checks++;
        if (bus.p_out[2] !== 1'b0) begin errors++; $display("FAIL cli_p_i: got %b expected 0", bus.p_out[2]); end
        checks++;
        if (bus.irq_mask !== 1'b1) begin errors++; $display("FAIL cli_mask_held: got %b expected 1", bus.irq_mask); end
        tick();
        checks++;
        if (bus.irq_mask !== 1'b1) begin errors++; $display("FAIL mask_no_done: got %b expected 1", bus.irq_mask); end
        bus.instr_done = 1;
        tick();
        checks++;
        if (bus.irq_mask !== 1'b0) begin errors++; $display("FAIL mask_next_instr: got %b expected 0", bus.irq_mask); end
        bus.pull = 1; bus.rti = 1; bus.data_in = 8'h04; bus.instr_done = 1;
        tick();
        checks++;
        if (bus.irq_mask !== 1'b1) begin errors++; $display("FAIL rti_mask_now: got %b expected 1", bus.irq_mask); end
        checks++;
        if (bus.p_out !== 8'h24) begin errors++; $display("FAIL rti_p_out: got %h expected 24", bus.p_out); end
    endtask

    task automatic test_pull();
        logic [7:0] exp_p;
        logic [7:0] exp_push;
        exp_p    = DEN ? 8'hEF : 8'hE7;
        exp_push = DEN ? 8'hFF : 8'hF7;
        bus.pull = 1; bus.data_in = 8'hFF;
        tick();
        bus.push_brk = 1;
        #1;
        checks++;
        if (bus.p_out !== exp_p) begin errors++; $display("FAIL pull_ff_p_out: got %h expected %h", bus.p_out, exp_p); end
        checks++;
        if (bus.p_push !== exp_push) begin errors++; $display("FAIL push_brk: got %h expected %h", bus.p_push, exp_push); end
        bus.push_brk = 0;
        #1;
        checks++;
        if (bus.p_push !== (exp_push & 8'hEF)) begin errors++; $display("FAIL push_irq: got %h expected %h", bus.p_push, exp_push & 8'hEF); end
        bus.pull = 1; bus.data_in = 8'hFF; bus.flag_cmd = FLAG_SEC; bus.upd_c = 1; bus.alu_carry = 0;
        tick();
        checks++;
        if (bus.p_out !== exp_p) begin errors++; $display("FAIL pull_wins_ff: got %h expected %h", bus.p_out, exp_p); end
        bus.pull = 1; bus.data_in = 8'h00; bus.flag_cmd = FLAG_SEC; bus.upd_nz = 1;
        bus.alu_sign = 1; bus.bit_op = 1; bus.upd_v = 1; bus.alu_overflow = 1;
        tick();
        checks++;
        if (bus.p_out !== 8'h20) begin errors++; $display("FAIL pull_wins_00: got %h expected 20", bus.p_out); end
    endtask

    task automatic test_reset_mid();
        bus.pull = 1; bus.data_in = 8'hC3;
        tick();
        reset_n = 0; bus.pull = 1; bus.data_in = 8'hFB; bus.flag_cmd = FLAG_SEI; bus.instr_done = 1;
        tick();
        checks++;
        if (bus.p_out !== 8'h24) begin errors++; $display("FAIL reset_mid_p_out: got %h expected 24", bus.p_out); end
        checks++;
        if (bus.irq_mask !== 1'b1) begin errors++; $display("FAIL reset_mid_mask: got %b expected 1", bus.irq_mask); end
        reset_n = 1;
        tick();
        checks++;
        if (bus.p_out !== 8'h24 || bus.irq_mask !== 1'b1) begin
            errors++; $display("FAIL reset_release_stale: got p=%h mask=%b expected p=24 mask=1", bus.p_out, bus.irq_mask);
        end
    endtask

    task automatic test_branch();
        for (int s = 0; s < 8; s++) begin
            bus.pull = 1; bus.data_in = 8'($urandom_range(0, 255));
            tick();
            bus.branch_sel = 3'(s);
            #1;
            checks++;
            if (bus.branch_taken !== m_branch(3'(s))) begin
                errors++; $display("FAIL branch_sel_%0d: got %b expected %b (p=%h)", s, bus.branch_taken, m_branch(3'(s)), bus.p_out);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            reset_n          = ($urandom_range(0, 39) != 0);
            bus.alu_carry    = 1'($urandom);
            bus.alu_overflow = 1'($urandom);
            bus.alu_zero     = 1'($urandom);
            bus.alu_sign     = 1'($urandom);
            bus.upd_nz       = 1'($urandom);
            bus.upd_c        = 1'($urandom);
            bus.upd_v        = 1'($urandom);
            bus.bit_op       = ($urandom_range(0, 3) == 0);
            bus.flag_cmd     = flag_cmd_t'($urandom_range(0, 7));
            bus.pull         = ($urandom_range(0, 7) == 0);
            bus.rti          = 1'($urandom);
            bus.data_in      = 8'($urandom);
            bus.instr_done   = ($urandom_range(0, 2) == 0);
            model_step();
            @(posedge clk);
            #1;
            bus.push_brk   = 1'($urandom);
            bus.branch_sel = 3'($urandom);
            reset_n        = 1'b1;
            #1;
            checks++;
            if (bus.p_out !== m_p() || bus.p_push !== m_push(bus.push_brk) ||
                bus.carry_in !== m_c || bus.irq_mask !== m_irq ||
                bus.branch_taken !== m_branch(bus.branch_sel)) begin
                errors++;
                $display("FAIL random_%0d: got p=%h push=%h c=%b mask=%b br=%b expected p=%h push=%h c=%b mask=%b br=%b",
                         k, bus.p_out, bus.p_push, bus.carry_in, bus.irq_mask, bus.branch_taken,
                         m_p(), m_push(bus.push_brk), m_c, m_irq, m_branch(bus.branch_sel));
            end
        end
        idle_inputs();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        idle_inputs();
        test_reset();
        test_alu_update();
        test_bit_op();
        test_irq_mask_delay();
        test_pull();
        test_reset_mid();
        test_branch();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
